// File: rtl/present_round_ctrl.sv
// Round-iterative PRESENT encryption controller: one S-box layer + pbox per clock, 80-bit key schedule.
// Define PRESENT_KEY128_EN to switch to the 128-bit key schedule.
module present_round_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    output logic         ready_o,
    input  logic [63:0]  pt_i,
    input  logic [127:0] key_i,
    output logic [63:0]  ct_o,
    output logic         valid_o,
    input  logic         ack_i,
    output logic         busy_o,
    output logic [4:0]   round_o
);

`ifdef PRESENT_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
`endif

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox(x[4*i +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] pbox(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] rc);
        logic [KW-1:0] r;
`ifdef PRESENT_KEY128_EN
        r = {k[66:0], k[127:67]};
        r[127:124] = sbox(r[127:124]);
        r[123:120] = sbox(r[123:120]);
        r[66:62]   = r[66:62] ^ rc;
`else
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ rc;
`endif
        return r;
    endfunction

    fsm_e          fsm_q, fsm_d;
    logic [63:0]   state_q, state_d;
    logic [KW-1:0] key_q, key_d;
    logic [4:0]    round_q, round_d;
    logic [63:0]   ct_q, ct_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

    logic [63:0]   round_out;
    logic [KW-1:0] next_key;

    always_comb begin
        round_out = pbox(sbox_layer(state_q ^ key_q[KW-1 -: 64]));
        next_key  = key_update(key_q, round_q);

        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        ct_d    = ct_q;
        ready_d = ready_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    fsm_d   = ROUND;
                    state_d = pt_i;
                    key_d   = key_i[KW-1:0];
                    round_d = 5'd1;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ROUND: begin
                state_d = round_out;
                key_d   = next_key;
                // Final round folds in the whitening key on the same edge.
                if (round_q == LAST_ROUND) begin
                    fsm_d   = DONE;
                    ct_d    = round_out ^ next_key[KW-1 -: 64];
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    round_d = 5'd0;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end
            DONE: begin
                if (ack_i) begin
                    fsm_d   = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                round_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            ct_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign ct_o    = ct_q;
    assign round_o = round_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed testbench for present_round_ctrl: known-answer vectors, handshake hold, mid-run reset, back-to-back.
// Honours PRESENT_KEY128_EN to pick the matching known answers.
`timescale 1ns/1ps
module tb_present_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic         ready_o;
    logic [63:0]  pt_i;
    logic [127:0] key_i;
    logic [63:0]  ct_o;
    logic         valid_o;
    logic         ack_i;
    logic         busy_o;
    logic [4:0]   round_o;

    int total = 0;
    int bad   = 0;

`ifdef PRESENT_KEY128_EN
    localparam logic [63:0] ZERO_CT = 64'h96DB702A2E6900AF;
`else
    localparam logic [63:0] ZERO_CT = 64'h5579C1387B228445;
`endif

    present_round_ctrl #(.ROUNDS(31)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .ready_o (ready_o),
        .pt_i    (pt_i),
        .key_i   (key_i),
        .ct_o    (ct_o),
        .valid_o (valid_o),
        .ack_i   (ack_i),
        .busy_o  (busy_o),
        .round_o (round_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one block from IDLE and waits (bounded) for valid_o; lat is edges after acceptance, -1 on timeout.
    task automatic do_block(input logic [63:0] pt, input logic [127:0] key,
                            output int lat, output logic ready_after, output logic [63:0] ct);
        @(negedge clk);
        pt_i    = pt;
        key_i   = key;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i     = 1'b0;
        pt_i        = ~pt;
        key_i       = ~key;
        ready_after = ready_o;
        lat         = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_o) begin
                lat = e;
                break;
            end
        end
        ct = ct_o;
    endtask

    task automatic ack_block();
        @(negedge clk);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || round_o !== 5'd0 || ct_o !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset: ready=%b valid=%b busy=%b round=%0d ct=%h, want 1 0 0 0 0",
                     ready_o, valid_o, busy_o, round_o, ct_o);
        end
    endtask

    task automatic test_vectors();
        logic [63:0]  pts  [4];
        logic [127:0] keys [4];
        logic [63:0]  exps [4];
        int           nvec;
        int           lat;
        logic         rdy;
        logic [63:0]  ct;
`ifdef PRESENT_KEY128_EN
        nvec    = 1;
        pts[0]  = 64'h0;
        keys[0] = 128'h0;
        exps[0] = 64'h96DB702A2E6900AF;
`else
        nvec    = 4;
        pts[0]  = 64'h0;
        keys[0] = 128'h0;
        exps[0] = 64'h5579C1387B228445;
        pts[1]  = 64'h0;
        keys[1] = {48'hDEADBEEFCAFE, 80'hFFFFFFFFFFFFFFFFFFFF};
        exps[1] = 64'hE72C46C0F5945049;
        pts[2]  = 64'hFFFFFFFFFFFFFFFF;
        keys[2] = 128'h0;
        exps[2] = 64'hA112FFC72F68417B;
        pts[3]  = 64'hFFFFFFFFFFFFFFFF;
        keys[3] = {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
        exps[3] = 64'h3333DCD3213210D2;
`endif
        for (int v = 0; v < nvec; v++) begin
            do_block(pts[v], keys[v], lat, rdy, ct);
            total++;
            if (rdy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL vec%0d_ready_drop: ready=%b want 0", v, rdy);
            end
            total++;
            if (lat !== 31) begin
                bad++;
                $display("[TB] FAIL vec%0d_latency: got %0d edges want 31", v, lat);
            end
            total++;
            if (ct !== exps[v]) begin
                bad++;
                $display("[TB] FAIL vec%0d_ct: got %h want %h", v, ct, exps[v]);
            end
            ack_block();
            total++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL vec%0d_ack: valid=%b ready=%b want 0 1", v, valid_o, ready_o);
            end
        end
    endtask

    task automatic test_ack_hold();
        int          lat;
        logic        rdy;
        logic [63:0] ct;
        do_block(64'h0, 128'h0, lat, rdy, ct);
        total++;
        if (lat !== 31) begin
            bad++;
            $display("[TB] FAIL hold_latency: got %0d want 31", lat);
        end
        for (int c = 0; c < 10; c++) begin
            start_i = (c == 3);
            pt_i    = 64'h0123456789ABCDEF;
            @(negedge clk);
            total++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || busy_o !== 1'b0 || ct_o !== ZERO_CT) begin
                bad++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b ready=%b busy=%b ct=%h want 1 0 0 %h",
                         c, valid_o, ready_o, busy_o, ct_o, ZERO_CT);
            end
        end
        start_i = 1'b0;
        ack_i   = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_ack: valid=%b ready=%b want 0 1", valid_o, ready_o);
        end
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || round_o !== 5'd0) begin
            bad++;
            $display("[TB] FAIL hold_no_queue: ready=%b busy=%b round=%0d want 1 0 0", ready_o, busy_o, round_o);
        end
    endtask

    task automatic test_mid_reset();
        int          lat;
        logic        rdy;
        logic [63:0] ct;
        logic        hit;
        @(negedge clk);
        pt_i    = 64'hFFFFFFFFFFFFFFFF;
        key_i   = {128{1'b1}};
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        hit     = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (round_o == 5'd15) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (hit !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reach_round15: round=%0d want 15", round_o);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || round_o !== 5'd0 || ct_o !== 64'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset: ready=%b valid=%b busy=%b round=%0d ct=%h want 1 0 0 0 0",
                     ready_o, valid_o, busy_o, round_o, ct_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_block(64'h0, 128'h0, lat, rdy, ct);
        total++;
        if (lat !== 31 || ct !== ZERO_CT) begin
            bad++;
            $display("[TB] FAIL post_reset_block: lat=%0d ct=%h want 31 %h", lat, ct, ZERO_CT);
        end
        ack_block();
    endtask

    // With start and ack tied high, DONE and IDLE each take one cycle, so results arrive every ROUNDS+2 edges.
    task automatic test_back_to_back();
        int          rise_cyc [3];
        int          nrise;
        logic        prev_busy;
        logic        prev_valid;
        logic [4:0]  prev_round;
        logic [4:0]  exp_round;
        @(negedge clk);
        pt_i       = 64'h0;
        key_i      = 128'h0;
        start_i    = 1'b1;
        ack_i      = 1'b1;
        nrise      = 0;
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        prev_round = 5'd0;
        for (int c = 0; c < 200 && nrise < 3; c++) begin
            @(negedge clk);
            if (busy_o) begin
                exp_round = prev_busy ? prev_round + 5'd1 : 5'd1;
                total++;
                if (round_o !== exp_round) begin
                    bad++;
                    $display("[TB] FAIL b2b_round c%0d: got %0d want %0d", c, round_o, exp_round);
                end
            end
            if (valid_o && !prev_valid) begin
                rise_cyc[nrise] = c;
                nrise++;
                total++;
                if (prev_round !== 5'd31 || ct_o !== ZERO_CT) begin
                    bad++;
                    $display("[TB] FAIL b2b_result%0d: last_round=%0d ct=%h want 31 %h", nrise, prev_round, ct_o, ZERO_CT);
                end
            end
            prev_busy  = busy_o;
            prev_valid = valid_o;
            prev_round = round_o;
        end
        start_i = 1'b0;
        ack_i   = 1'b0;
        total++;
        if (nrise !== 3) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d results want 3", nrise);
        end else begin
            for (int k = 1; k < 3; k++) begin
                total++;
                if (rise_cyc[k] - rise_cyc[k-1] !== 33) begin
                    bad++;
                    $display("[TB] FAIL b2b_period%0d: got %0d want 33", k, rise_cyc[k] - rise_cyc[k-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        ack_i   = 1'b0;
        pt_i    = 64'h0;
        key_i   = 128'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_vectors();
        test_ack_hold();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
